// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants and tone sequencer state encoding
package audio_pkg;

    localparam int ROM_AW = 5;
    localparam int SAMPLE_W = 4;
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing one sample tick every CLK_DIV cycles
module tick_prescaler #(
    parameter int CLK_DIV = 1134
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    // Count 0..CLK_DIV-1 forever; never restarted by note traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - note player: phase accumulator into sine ROM, timed rest; option TONE_ZERO_CROSS_EN
module tone_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_DIV   = 1134,
    parameter int PHASE_W   = 16,
    parameter int DUR_W     = 16,
    parameter int GAP_TICKS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                note_valid,
    output logic                note_ready,
    input  logic [PHASE_W-1:0]  note_inc,
    input  logic [DUR_W-1:0]    note_dur,
    input  logic                abort,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_data,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                busy
);

    localparam int GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
    localparam state_t AFTER_NOTE = (GAP_TICKS != 0) ? ST_GAP : ST_IDLE;

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PHASE_W-1:0]   inc_q, inc_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [SAMPLE_W-1:0]  sample_d;
    logic                 valid_d;
    logic                 tick;
    logic [PHASE_W:0]     sum;
    logic                 last_tick;
    logic                 stop;

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign note_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rom_addr   = phase_q[PHASE_W-1 -: ROM_AW];
    assign sum        = {1'b0, phase_q} + {1'b0, inc_q};
    assign last_tick  = (dur_q <= DUR_W'(1));

`ifdef TONE_ZERO_CROSS_EN
    // Once the duration is spent, hold on until the phase wraps so the note ends at a cycle boundary.
    assign stop = last_tick && (sum[PHASE_W] || (inc_q == '0));
`else
    assign stop = last_tick;
`endif

    // Next-state and datapath updates; abort overrides ticks and accepts.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        inc_d    = inc_q;
        dur_d    = dur_q;
        gap_d    = gap_q;
        sample_d = sample_out;
        valid_d  = 1'b0;
        if (abort) begin
            state_d  = ST_IDLE;
            phase_d  = '0;
            dur_d    = '0;
            gap_d    = '0;
            sample_d = MIDSCALE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (note_valid) begin
                        phase_d = '0;
                        inc_d   = note_inc;
                        dur_d   = note_dur;
                        gap_d   = '0;
                        state_d = (note_dur != '0) ? ST_PLAY : AFTER_NOTE;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        sample_d = rom_data;
                        valid_d  = 1'b1;
                        phase_d  = sum[PHASE_W-1:0];
                        if (dur_q != '0) begin
                            dur_d = dur_q - DUR_W'(1);
                        end
                        if (stop) begin
                            state_d = AFTER_NOTE;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        sample_d = MIDSCALE;
                        valid_d  = 1'b1;
                        if (gap_q == GAP_W'(GAP_LAST)) begin
                            gap_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            gap_d = gap_q + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset drops any note in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            inc_q        <= '0;
            dur_q        <= '0;
            gap_q        <= '0;
            sample_out   <= MIDSCALE;
            sample_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            inc_q        <= inc_d;
            dur_q        <= dur_d;
            gap_q        <= gap_d;
            sample_out   <= sample_d;
            sample_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - directed self-checking bench for tone_sequencer
module tb_tone_sequencer;

    localparam int PHASE_W = 16;
    localparam int DUR_W   = 16;
`ifdef TONE_ZERO_CROSS_EN
    localparam int EXP_T6 = 32;
`else
    localparam int EXP_T6 = 10;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               note_valid = 1'b0;
    logic               note_ready;
    logic [PHASE_W-1:0] note_inc = '0;
    logic [DUR_W-1:0]   note_dur = '0;
    logic               abort = 1'b0;
    logic [4:0]         rom_addr;
    logic [3:0]         rom_data;
    logic [3:0]         sample_out;
    logic               sample_valid;
    logic               busy;

    logic [3:0] sine_tab [0:31] = '{
        4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE, 4'hE, 4'hF,
        4'hF, 4'hF, 4'hE, 4'hE, 4'hD, 4'hC, 4'hA, 4'h9,
        4'h7, 4'h6, 4'h5, 4'h3, 4'h2, 4'h1, 4'h1, 4'h0,
        4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6
    };

    int passed = 0;
    int total  = 0;

    logic [3:0] samp_q [$];
    logic [4:0] addr_q [$];
    logic [3:0] exp_q  [$];
    logic [4:0] prev_addr = '0;

    assign rom_data = sine_tab[rom_addr];

    tone_sequencer #(
        .CLK_DIV   (4),
        .PHASE_W   (PHASE_W),
        .DUR_W     (DUR_W),
        .GAP_TICKS (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .note_valid   (note_valid),
        .note_ready   (note_ready),
        .note_inc     (note_inc),
        .note_dur     (note_dur),
        .abort        (abort),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Capture every sample pulse with the ROM address that was live during its tick.
    always @(negedge clk) begin
        if (sample_valid) begin
            samp_q.push_back(sample_out);
            addr_q.push_back(prev_addr);
        end
        prev_addr = rom_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_note(input logic [PHASE_W-1:0] inc, input logic [DUR_W-1:0] dur);
        int k;
        k = 0;
        while (!note_ready && k < 500) begin
            step(1);
            k++;
        end
        if (k >= 500) check("ready_timeout", 32'd0, 32'd1);
        note_valid = 1'b1;
        note_inc   = inc;
        note_dur   = dur;
        step(1);
        note_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 1000) begin
            step(1);
            k++;
        end
        if (k >= 1000) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
        step(1);
    endtask

    task automatic wait_samples(input int n);
        int k;
        k = 0;
        while (samp_q.size() < n && k < 1000) begin
            step(1);
            k++;
        end
        if (k >= 1000) check("sample_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare_samples(input string tag);
        check({tag, "_count"}, samp_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < samp_q.size(); i++) begin
            check($sformatf("%s_s%0d", tag, i), samp_q[i], exp_q[i]);
        end
    endtask

    task automatic clear_capture();
        samp_q.delete();
        addr_q.delete();
        exp_q.delete();
    endtask

    initial begin
        step(3);
        check("rst_sample_out", sample_out, 4'h8);
        check("rst_sample_valid", sample_valid, 1'b0);
        check("rst_note_ready", note_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rom_addr", rom_addr, 5'd0);
        rst_n = 1'b1;
        step(2);

        // Full sine cycle followed by the rest.
        clear_capture();
        send_note(16'h0800, 16'd32);
        check("t1_busy", busy, 1'b1);
        wait_idle("t1");
        for (int i = 0; i < 32; i++) exp_q.push_back(sine_tab[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(4'h8);
        compare_samples("t1");
        check("t1_note_ready", note_ready, 1'b1);

        // Half-cycle steps alternate between addresses 0 and 16.
        clear_capture();
        send_note(16'h8000, 16'd4);
        wait_idle("t2");
        exp_q = '{4'h8, 4'h7, 4'h8, 4'h7, 4'h8, 4'h8, 4'h8, 4'h8};
        compare_samples("t2");
        for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
            check($sformatf("t2_addr%0d", i), addr_q[i], (i % 2 == 0) ? 5'd0 : 5'd16);
        end

        // Zero duration: rest only.
        clear_capture();
        send_note(16'h0800, 16'd0);
        wait_idle("t3");
        exp_q = '{4'h8, 4'h8, 4'h8, 4'h8};
        compare_samples("t3");

        // Abort mid-note, then a fresh note plays normally.
        clear_capture();
        send_note(16'h0800, 16'd32);
        wait_samples(5);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t4_busy", busy, 1'b0);
        check("t4_sample_out", sample_out, 4'h8);
        check("t4_sample_valid", sample_valid, 1'b0);
        clear_capture();
        step(40);
        check("t4_quiet", samp_q.size(), 0);
        send_note(16'h8000, 16'd2);
        wait_idle("t4b");
        exp_q = '{4'h8, 4'h7, 4'h8, 4'h8, 4'h8, 4'h8};
        compare_samples("t4b");

        // Reset mid-note clears everything at once.
        clear_capture();
        send_note(16'h0800, 16'd32);
        wait_samples(3);
        while (sample_out == 4'h8) step(1);
        rst_n = 1'b0;
        #1;
        check("t5_sample_out", sample_out, 4'h8);
        check("t5_sample_valid", sample_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("t5_note_ready", note_ready, 1'b1);

        // Short note, optionally extended to the end of the sine cycle.
        clear_capture();
        send_note(16'h0800, 16'd10);
        wait_idle("t6");
        for (int i = 0; i < EXP_T6; i++) exp_q.push_back(sine_tab[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(4'h8);
        compare_samples("t6");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
